// File: rtl/sw_rsp_serializer.sv
// Response serializer: buffers completed software responses in a small FIFO and
// streams each one out as NFLITS flits, most significant word first. Denied
// responses are zeroed before they are stored so their payload never persists.
module sw_rsp_serializer #(
    parameter int unsigned PKT_S = 32,
    parameter int unsigned D_S   = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rsp_in_valid,
    output logic                       rsp_in_ready,
    input  logic                       rsp_in_grant,
    input  logic [D_S-1:0]             rsp_in_data,
    input  logic                       rd_ready,
    output logic [PKT_S-1:0]           data_out,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic                       rsp_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned NFLITS = D_S / PKT_S;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW     = (NFLITS > 1) ? $clog2(NFLITS) : 1;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // Each entry is {grant, payload}; payload already zeroed for denials.
    logic [D_S:0]     mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    state_e           state_q;
    logic [D_S-1:0]   shift_q;
    logic [IW-1:0]    idx_q;
    logic [PKT_S-1:0] data_out_q;
    logic             rsp_valid_q, rsp_err_q, rsp_last_q;

    logic             push, pop, last_consume;
    logic [D_S:0]     head;
    logic [D_S-1:0]   head_payload;
    logic             head_grant;

    assign rsp_in_ready = (count_q < CW'(DEPTH));
    assign push         = rsp_in_valid & rsp_in_ready;
    assign last_consume = (state_q == StSend) & rd_ready & (idx_q == IW'(NFLITS - 1));
    // Emptiness is judged on the registered count, so a same-cycle push is not popped.
    assign pop          = (count_q != '0) & ((state_q == StIdle) | last_consume);

    assign head         = mem_q[rd_ptr_q];
    assign head_payload = head[D_S-1:0];
    assign head_grant   = head[D_S];

    assign data_out   = data_out_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_last   = rsp_last_q;
    assign fifo_count = count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next occupancy from push/pop of this cycle.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; denied payloads are scrubbed on entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rsp_in_grant, rsp_in_grant ? rsp_in_data : {D_S{1'b0}}};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // Serializer FSM with registered outputs; a pop always (re)loads a fresh packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            idx_q       <= '0;
            data_out_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else if (pop) begin
            state_q     <= StSend;
            idx_q       <= '0;
            data_out_q  <= head_payload[D_S-1 -: PKT_S];
            shift_q     <= head_payload << PKT_S;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~head_grant;
            rsp_last_q  <= (NFLITS == 1);
        end else if (state_q == StSend && rd_ready) begin
            if (idx_q == IW'(NFLITS - 1)) begin
                state_q     <= StIdle;
                idx_q       <= '0;
                data_out_q  <= '0;
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_last_q  <= 1'b0;
            end else begin
                idx_q      <= idx_q + IW'(1);
                data_out_q <= shift_q[D_S-1 -: PKT_S];
                shift_q    <= shift_q << PKT_S;
                rsp_last_q <= ((idx_q + IW'(1)) == IW'(NFLITS - 1));
            end
        end
    end

endmodule
